// File: rtl/can_rx_frame_ctrl.sv
// can_rx_frame_ctrl: sequences the CAN RX bit sampler for one standard-format
// (11-bit ID) frame, removes stuff bits, parses ID/RTR/IDE/r0/DLC/data and
// publishes either the decoded frame or a one-cycle error pulse.
module can_rx_frame_ctrl #(
  parameter int unsigned clk_speed_MHz      = 100,
  parameter int unsigned can_bit_rate_Kbits = 1000,
  parameter int unsigned timeout_bits       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        sample_bit,
  input  logic        sample_valid,
  output logic        sample_en,
  output logic        busy,
  output logic [10:0] id,
  output logic        rtr,
  output logic [3:0]  dlc,
  output logic [63:0] data,
  output logic        frame_valid,
  output logic        stuff_err,
  output logic        form_err
);

  localparam int unsigned CPB      = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int unsigned WD_LIMIT = timeout_bits * CPB;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              last_q, last_d;
  logic [2:0]        run_q, run_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [6:0]        len_q, len_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_nxt;
  logic [10:0]       id_w_q, id_w_d;
  logic              rtr_w_q, rtr_w_d;
  logic [3:0]        dlc_w_q, dlc_w_d;
  logic [63:0]       data_w_q, data_w_d;
  logic [10:0]       id_q, id_d;
  logic              rtr_q, rtr_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [63:0]       data_q, data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              stuff_err_q, stuff_err_d;
  logic              form_err_q, form_err_d;
  logic              sample_en_q, sample_en_d;
  logic              busy_q, busy_d;
  logic              fall_c;
  logic              data_evt;
  logic [3:0]        dlc_full;
  logic [3:0]        nbytes;

  assign fall_c = prev_q & ~sync2_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state, destuffing, field parsing, watchdog and registered output values
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    run_d         = run_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    id_w_d        = id_w_q;
    rtr_w_d       = rtr_w_q;
    dlc_w_d       = dlc_w_q;
    data_w_d      = data_w_q;
    id_d          = id_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    frame_valid_d = 1'b0;
    stuff_err_d   = 1'b0;
    form_err_d    = 1'b0;
    data_evt      = 1'b0;
    dlc_full      = {dlc_w_q[2:0], sample_bit};
    nbytes        = 4'd0;
    wd_nxt        = wd_q + WD_W'(1);
    wd_d          = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          state_d  = S_SOF;
          last_d   = 1'b1;
          run_d    = 3'd0;
          cnt_d    = 7'd0;
          len_d    = 7'd0;
          id_w_d   = 11'd0;
          rtr_w_d  = 1'b0;
          dlc_w_d  = 4'd0;
          data_w_d = 64'd0;
        end
      end
      S_SOF: begin
        if (sample_valid) begin
          if (!sample_bit) begin
            state_d = S_ARB;
            last_d  = 1'b0;
            run_d   = 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ARB, S_CTRL, S_DATA: begin
        if (sample_valid) begin
          if (run_q == 3'd5) begin
            if (sample_bit == last_q) begin
              stuff_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              last_d = sample_bit;
              run_d  = 3'd1;
            end
          end else begin
            data_evt = 1'b1;
            last_d   = sample_bit;
            run_d    = (sample_bit == last_q) ? run_q + 3'd1 : 3'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Route each destuffed bit into the field currently being parsed
    if (data_evt) begin
      cnt_d = cnt_q + 7'd1;
      unique case (state_q)
        S_ARB: begin
          if (cnt_q < 7'd11) begin
            id_w_d = {id_w_q[9:0], sample_bit};
          end else begin
            rtr_w_d = sample_bit;
            cnt_d   = 7'd0;
            state_d = S_CTRL;
          end
        end
        S_CTRL: begin
          if (cnt_q == 7'd0) begin
            if (sample_bit) begin
              form_err_d = 1'b1;
              state_d    = S_IDLE;
            end
          end else if (cnt_q >= 7'd2) begin
            dlc_w_d = dlc_full;
            if (cnt_q == 7'd5) begin
              nbytes  = rtr_w_q ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);
              len_d   = {nbytes, 3'b000};
              cnt_d   = 7'd0;
              state_d = (nbytes == 4'd0) ? S_DONE : S_DATA;
            end
          end
        end
        S_DATA: begin
          data_w_d[6'd63 - cnt_q[5:0]] = sample_bit;
          if (cnt_q == len_q - 7'd1) state_d = S_DONE;
        end
        default: ;
      endcase
    end

    // Watchdog: a sample_valid always clears it; expiry without one is a form error
    if (state_q inside {S_SOF, S_ARB, S_CTRL, S_DATA}) begin
      if (sample_valid) begin
        wd_d = '0;
      end else if (wd_nxt == WD_W'(WD_LIMIT)) begin
        wd_d       = '0;
        form_err_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        wd_d = wd_nxt;
      end
    end else begin
      wd_d = '0;
    end

    // Publish the working copies only when a frame completes
    if (state_d == S_DONE && state_q != S_DONE) begin
      frame_valid_d = 1'b1;
      id_d          = id_w_d;
      rtr_d         = rtr_w_d;
      dlc_d         = dlc_w_d;
      data_d        = data_w_d;
    end

    sample_en_d = state_d inside {S_SOF, S_ARB, S_CTRL, S_DATA};
    busy_d      = (state_d != S_IDLE);
  end

  // State, working and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b0;
      run_q         <= 3'd0;
      cnt_q         <= 7'd0;
      len_q         <= 7'd0;
      wd_q          <= '0;
      id_w_q        <= 11'd0;
      rtr_w_q       <= 1'b0;
      dlc_w_q       <= 4'd0;
      data_w_q      <= 64'd0;
      id_q          <= 11'd0;
      rtr_q         <= 1'b0;
      dlc_q         <= 4'd0;
      data_q        <= 64'd0;
      frame_valid_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      form_err_q    <= 1'b0;
      sample_en_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      wd_q          <= wd_d;
      id_w_q        <= id_w_d;
      rtr_w_q       <= rtr_w_d;
      dlc_w_q       <= dlc_w_d;
      data_w_q      <= data_w_d;
      id_q          <= id_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      frame_valid_q <= frame_valid_d;
      stuff_err_q   <= stuff_err_d;
      form_err_q    <= form_err_d;
      sample_en_q   <= sample_en_d;
      busy_q        <= busy_d;
    end
  end

  assign sample_en   = sample_en_q;
  assign busy        = busy_q;
  assign id          = id_q;
  assign rtr         = rtr_q;
  assign dlc         = dlc_q;
  assign data        = data_q;
  assign frame_valid = frame_valid_q;
  assign stuff_err   = stuff_err_q;
  assign form_err    = form_err_q;

endmodule
